// File: rtl/xgcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xgcd_pkg
//  Description : Shared constants, fetch state encoding and address helper
//                for the XGCD argument store and its operand fetcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package xgcd_pkg;

  localparam int DATA_W    = 64;
  localparam int NUM_WORDS = 32;
  localparam int IDX_W     = 5;
  localparam int ADDR_W    = 12;

  localparam logic [3:0] BANK_A = 4'h0;
  localparam logic [3:0] BANK_B = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_CAP   = 3'd3,
    ST_STALL = 3'd4,
    ST_DRAIN = 3'd5
  } fetch_state_t;

  // Byte address of word idx in a bank; the argument store decodes the same way.
  function automatic logic [ADDR_W-1:0] arg_addr(input logic [3:0] bank,
                                                 input logic [IDX_W-1:0] idx);
    return {bank, idx, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/xgcd_operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : xgcd_operand_fetch_if
//  Description : Valid/ready operand-pair stream from the fetcher to the
//                XGCD datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xgcd_operand_fetch_if;

  logic                          OUT_VALID;
  logic                          OUT_READY;
  logic [xgcd_pkg::DATA_W-1:0]   OUT_A;
  logic [xgcd_pkg::DATA_W-1:0]   OUT_B;
  logic [xgcd_pkg::IDX_W-1:0]    OUT_IDX;
  logic                          OUT_LAST;

  modport master (
    output OUT_VALID, OUT_A, OUT_B, OUT_IDX, OUT_LAST,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID, OUT_A, OUT_B, OUT_IDX, OUT_LAST,
    output OUT_READY
  );

endinterface
`default_nettype wire

// File: rtl/xgcd_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : xgcd_operand_fetch
//  Description : Reads A[k], B[k] pairs from the argument store over a
//                1-cycle-latency read port and streams them to the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module xgcd_operand_fetch
  import xgcd_pkg::*;
(
  input  wire                  CLK,
  input  wire                  RESET,
  input  wire                  START,
  input  wire                  ABORT,
  input  wire [IDX_W:0]        NWORDS,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 MEM_CEn,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  input  wire [DATA_W-1:0]     MEM_RDATA,
  xgcd_operand_fetch_if.master out
);

  localparam logic [IDX_W:0]   c_max_words = (IDX_W+1)'(NUM_WORDS);
  localparam logic [IDX_W:0]   c_n_one     = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [IDX_W:0]    r_n;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_a_hold;
  logic [DATA_W-1:0] r_b_hold;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;
  logic [IDX_W-1:0]  r_out_idx;
  logic              r_out_last;
  logic              r_done;

  logic              w_handshake;
  logic              w_slot_free;
  logic              w_is_last;
  logic              w_load;
  logic [DATA_W-1:0] w_load_b;
  logic [IDX_W:0]    w_n_clamped;

  assign w_handshake = r_out_valid & out.OUT_READY;
  assign w_slot_free = ~r_out_valid | out.OUT_READY;
  assign w_is_last   = ({1'b0, r_idx} == (r_n - c_n_one));
  assign w_load      = ((r_state == ST_CAP) || (r_state == ST_STALL)) && w_slot_free && !ABORT;
  // In CAP the B word is still on the read bus; in STALL it was parked in b_hold.
  assign w_load_b    = (r_state == ST_CAP) ? MEM_RDATA : r_b_hold;
  assign w_n_clamped = (NWORDS > c_max_words) ? c_max_words : NWORDS;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ABORT) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (START && (NWORDS != '0)) w_state_nxt = ST_RD_A;
        ST_RD_A:  w_state_nxt = ST_RD_B;
        ST_RD_B:  w_state_nxt = ST_CAP;
        ST_CAP:   if (w_slot_free) w_state_nxt = w_is_last ? ST_DRAIN : ST_RD_A;
                  else             w_state_nxt = ST_STALL;
        ST_STALL: if (w_slot_free) w_state_nxt = w_is_last ? ST_DRAIN : ST_RD_A;
        ST_DRAIN: if (w_handshake) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY     = (r_state != ST_IDLE);
    MEM_CEn  = 1'b1;
    MEM_ADDR = '0;
    case (r_state)
      ST_RD_A: begin
        MEM_CEn  = 1'b0;
        MEM_ADDR = arg_addr(BANK_A, r_idx);
      end
      ST_RD_B: begin
        MEM_CEn  = 1'b0;
        MEM_ADDR = arg_addr(BANK_B, r_idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_n         <= '0;
      r_idx       <= '0;
      r_a_hold    <= '0;
      r_b_hold    <= '0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ABORT) begin
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (START) begin
            if (NWORDS == '0) begin
              r_done <= 1'b1;
            end else begin
              r_n   <= w_n_clamped;
              r_idx <= '0;
            end
          end
          ST_RD_B:  r_a_hold <= MEM_RDATA;
          ST_CAP:   if (!w_slot_free) r_b_hold <= MEM_RDATA;
          ST_DRAIN: if (w_handshake) r_done <= 1'b1;
          default: ;
        endcase

        if (w_load) begin
          r_out_valid <= 1'b1;
          r_out_a     <= r_a_hold;
          r_out_b     <= w_load_b;
          r_out_idx   <= r_idx;
          r_out_last  <= w_is_last;
          if (!w_is_last) r_idx <= r_idx + c_idx_one;
        end else if (w_handshake) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign DONE          = r_done;
  assign out.OUT_VALID = r_out_valid;
  assign out.OUT_A     = r_out_a;
  assign out.OUT_B     = r_out_b;
  assign out.OUT_IDX   = r_out_idx;
  assign out.OUT_LAST  = r_out_last;

endmodule
`default_nettype wire

// File: doc/xgcd_operand_fetch.md
Name: xgcd_operand_fetch

Overview:
Downstream consumer of the XGCD argument store (banks ARG_A and ARG_B, 32 x 64-bit words each, behind the AXI-to-SRAM bridge).
- On START, reads word k of ARG_A and then word k of ARG_B for k = 0..NWORDS-1, over a single SRAM-style read port with 1-cycle read latency.
- Emits each {A[k], B[k]} pair as one beat on a valid/ready stream feeding the XGCD datapath.
- Pulses DONE after the last beat is accepted.

Parameters:
- DATA_W, 64, operand word width.
- NUM_WORDS, 32, words per bank.
- IDX_W, 5, word index width (log2 NUM_WORDS).

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-high.
- START  in  1  single-cycle start request.
- ABORT  in  1  synchronous cancel.
- NWORDS  in  IDX_W+1  words to fetch; valid range 0..32, sampled on START.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle completion pulse.
- MEM_CEn  out  1  read strobe, active-low.
- MEM_ADDR  out  12  byte address.
- MEM_RDATA  in  DATA_W  read data, valid the cycle after MEM_CEn=0.
- OUT_VALID  out  1  pair valid.
- OUT_READY  in  1  pair accepted.
- OUT_A  out  DATA_W  operand A[k].
- OUT_B  out  DATA_W  operand B[k].
- OUT_IDX  out  IDX_W  k.
- OUT_LAST  out  1  k == NWORDS-1.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; BUSY=0, DONE=0, MEM_CEn=1, MEM_ADDR=0, OUT_VALID=0, OUT_A=OUT_B=0, OUT_IDX=0, OUT_LAST=0. This applies mid-operation too: the stream is dropped with no DONE.
- Address map: A[k] = {4'h0, k, 3'b000}; B[k] = {4'h1, k, 3'b000}. MEM_ADDR=0 and MEM_CEn=1 whenever no read is issued.
- States: IDLE, RD_A, RD_B, CAP, STALL, DRAIN.
- IDLE:
  - START with NWORDS != 0: latch n, set idx=0, go to RD_A.
  - START with NWORDS == 0: DONE=1 next cycle, remain IDLE, no reads issued.
  - NWORDS > 32 is clamped to 32.
- RD_A: MEM_CEn=0, address A[idx]; go to RD_B.
- RD_B: MEM_CEn=0, address B[idx]; capture MEM_RDATA into a_hold; go to CAP.
- CAP: MEM_RDATA holds B[idx]. The output slot is free when OUT_VALID==0 or OUT_READY==1.
  - Slot free: load OUT_A=a_hold, OUT_B=MEM_RDATA, OUT_IDX=idx, OUT_LAST=(idx==n-1), OUT_VALID=1. Then go to DRAIN if last; otherwise idx++ and go to RD_A.
  - Slot not free: store b_hold and go to STALL.
- STALL: no reads issued. On OUT_VALID & OUT_READY, load the held pair and take the same next-state rule as CAP.
- Output register: the handshake clears OUT_VALID unless a new pair is loaded in the same cycle. OUT_A, OUT_B, OUT_IDX and OUT_LAST stay stable while OUT_VALID & !OUT_READY.
- DRAIN: on handshake of the last beat, go to IDLE with DONE=1 for exactly one cycle.
- Timing with OUT_READY held high and START sampled at edge 0:
  - RD_A in cycle 1; first OUT_VALID in cycle 4.
  - Throughput is one pair per 3 cycles.
  - DONE is high in cycle 3n+2.
  - BUSY is high in cycles 1..3n+1.
- START while BUSY is ignored.
- ABORT (any state != IDLE): next cycle is IDLE with OUT_VALID=0, MEM_CEn=1 and no DONE. ABORT takes priority over a simultaneous START or handshake.
- MEM_RDATA is sampled only in RD_B and CAP.

Decomposition:
- Shared package xgcd_pkg holds:
  - DATA_W / NUM_WORDS / IDX_W constants.
  - bank base constants BANK_A=4'h0 and BANK_B=4'h1.
  - the fetch state enum.
  - the address-composition function, shared with the argument store decode.
- No sub-module required. The FSM, the a_hold/b_hold registers and the output register live in a single module.

Test Plan:
- Single burst: preload A[k]=0xA000+k, B[k]=0xB000+k; NWORDS=4, OUT_READY=1 → 4 beats (0xA000..3, 0xB000..3), OUT_IDX 0..3, OUT_LAST only on idx 3, DONE in cycle 14, BUSY cycles 1..13.
- Backpressure: NWORDS=2, OUT_READY=0 in cycles 4..9 → beat 0 held stable; FSM in STALL with MEM_CEn=1; beat 1 appears the cycle after the handshake at cycle 10; DONE follows the last handshake by 1 cycle.
- Full bank: NWORDS=32 → final reads at 0x0F8 and 0x1F8, OUT_IDX=31 with OUT_LAST=1, exactly 32 beats, DONE in cycle 98.
- Zero length: NWORDS=0 → DONE=1 in cycle 1, BUSY never high, MEM_CEn never low.
- START while BUSY is ignored (no extra beats). ABORT asserted in cycle 5 → IDLE in cycle 6, OUT_VALID=0, DONE never pulses; a following START works normally.
- RESET asserted mid-stream (cycle 7) → all outputs zero immediately (asynchronous); after release, IDLE, and a new START from idx 0 produces correct data.
